// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the 8N1 UART transmit path.
//   uart_state_e            : transmitter FSM state (2-bit encoding)
//   DATA_BITS / FRAME_BITS  : payload bits and total bits per 8N1 frame
//   DEFAULT_CLOCKS_PER_BAUD : 12 MHz system clock / 115200 baud
//   frame_bits()            : builds the on-wire bit order of a byte
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS               = 8;
    localparam int FRAME_BITS              = 10;
    localparam int DEFAULT_CLOCKS_PER_BAUD = 104;

    // Bit i of the result is the line level during bit period i of the frame
    // (start bit, eight data bits LSB first, stop bit).
    function automatic logic [9:0] frame_bits(input logic [7:0] byte_i);
        return {1'b1, byte_i, 1'b0};
    endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Free-running bit-period timer. While i_run is high it counts
// 0..CLOCKS_PER_BAUD-1 and raises o_bit_end for the single cycle in which the
// count sits at its terminal value; the count then wraps to 0. While i_run is
// low the count is held at 0, so a new frame always starts a full period.
//   i_clk     : system clock, rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_run     : count enable (high while a frame is on the line)
//   o_bit_end : one-cycle strobe on the last clock of each bit period
// -----------------------------------------------------------------------------
module uart_baud_counter #(
    parameter int CLOCKS_PER_BAUD = 104,
    parameter int CNT_W           = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    output logic o_bit_end
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_terminal_s;

    // Next count: hold at zero when stopped, wrap at the terminal count.
    always_comb begin
        at_terminal_s = (cnt_q == TERMINAL);
        if (!i_run) begin
            cnt_d = '0;
        end else if (at_terminal_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_bit_end = i_run && at_terminal_s;

endmodule : uart_baud_counter

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// 8N1 UART transmitter fed by the byte-select mux. One byte is taken per
// valid/ready handshake and shifted out LSB first between a low start bit and
// a high stop bit, each bit lasting CLOCKS_PER_BAUD system clocks.
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset (aborts any frame in flight)
//   i_data  : byte to send (mux output z)
//   i_valid : i_data holds a byte to send
//   o_ready : a byte can be accepted this cycle
//   o_tx    : serial line, idle high
//   o_busy  : frame in progress (always the inverse of o_ready)
// All outputs come straight from flops and are computed from the next state,
// so the line changes on the same edge as the state (the accept edge itself
// drives the start bit). A frame occupies exactly 10*CLOCKS_PER_BAUD cycles.
// -----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
    parameter int CNT_W           = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy
);

    if ((CLOCKS_PER_BAUD < 2) || (CLOCKS_PER_BAUD > 65535)) begin : g_bad_cpb
        $error("uart_tx_serializer: CLOCKS_PER_BAUD=%0d outside 2..65535", CLOCKS_PER_BAUD);
    end

    if ((CNT_W < 1) || (CNT_W > 62) ||
        ((64'd1 << CNT_W) <= 64'(CLOCKS_PER_BAUD))) begin : g_bad_cnt_w
        $error("uart_tx_serializer: CNT_W=%0d too narrow for CLOCKS_PER_BAUD=%0d",
               CNT_W, CLOCKS_PER_BAUD);
    end

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e state_q;
    uart_state_e state_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic [2:0]  bit_idx_q;
    logic [2:0]  bit_idx_d;
    logic        tx_q;
    logic        tx_d;
    logic        ready_q;
    logic        ready_d;
    logic        busy_q;
    logic        accept_s;
    logic        run_s;
    logic        bit_end_s;

    assign accept_s = i_valid && ready_q;
    assign run_s    = (state_q != IDLE);

    uart_baud_counter #(
        .CLOCKS_PER_BAUD (CLOCKS_PER_BAUD),
        .CNT_W           (CNT_W)
    ) u_baud (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_run     (run_s),
        .o_bit_end (bit_end_s)
    );

    // State register plus the datapath and output flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= !ready_d;
        end
    end

    // Next-state logic: frame sequencing, byte capture and shifting.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d   = START;
                    shift_d   = i_data;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d   = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d   = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    // Shift so that shift[0] always holds the bit on the line.
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d   = STOP;
                        bit_idx_d = 3'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d   = IDLE;
                shift_d   = 8'd0;
                bit_idx_d = 3'd0;
            end
        endcase
    end

    // Output decode from the next state so outputs register alongside it.
    always_comb begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        case (state_d)
            IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
            end
            START: begin
                tx_d    = 1'b0;
                ready_d = 1'b0;
            end
            DATA: begin
                tx_d    = shift_d[0];
                ready_d = 1'b0;
            end
            STOP: begin
                tx_d    = 1'b1;
                ready_d = 1'b0;
            end
            default: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    assign o_tx    = tx_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;

endmodule : uart_tx_serializer
